// File: rtl/mips_if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package mips_if_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'hE000_0000;
    localparam logic [5:0]  HALT_OPCODE      = 6'b101101;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_FULL,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel: one outstanding request, ack may be same-cycle.
interface if_fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ack
    );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry store for an instruction and its PC+4, used when memory answers during a hold.
module if_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, redirects, holds and halt.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = mips_if_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR   = mips_if_pkg::NOP_INSTR,
    parameter logic [5:0]  HALT_OPCODE = mips_if_pkg::HALT_OPCODE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     jump_taken,
    input  logic [31:0]              jump_target,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              Instruction_out,
    output logic [31:0]              PC_out,
    output logic                     inst_valid,
    output logic                     halt_out,
    output logic [31:0]              pc_current
);

    import mips_if_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic         halt_q, halt_d;
    logic         squash_q, squash_d;
    logic         pending_q, pending_d;
    logic         squash_on_reset;

    logic         req;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  next_pc;

    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  deliver_pc;

    logic         skid_load, skid_unload, skid_clear, skid_valid;
    logic [31:0]  skid_instr, skid_pc;

    assign req         = (state_q == S_REQ) && !reset;
    assign redirect    = branch_taken || jump_taken;
    assign redirect_pc = branch_taken ? branch_target : jump_target;
    assign next_pc     = req_addr_q + 32'd4;

    // A request left hanging by reset still gets its ack later; that ack must be dropped.
    assign squash_on_reset = !imem.ack && (squash_q || pending_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        valid_d       = valid_q;
        halt_d        = halt_q;
        squash_d      = squash_q;
        pending_d     = req && !imem.ack;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem.rdata;
        deliver_pc    = next_pc;

        if (redirect) begin
            state_d    = S_REQ;
            pc_d       = redirect_pc;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            halt_d     = 1'b0;
            skid_clear = 1'b1;
            // Address must stay put until the in-flight request is answered.
            if (req && !imem.ack) begin
                squash_d = 1'b1;
            end else begin
                squash_d   = 1'b0;
                req_addr_d = redirect_pc;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (!hold) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                    if (imem.ack && squash_q) begin
                        squash_d   = 1'b0;
                        req_addr_d = pc_q;
                    end else if (imem.ack && hold) begin
                        skid_load = 1'b1;
                        state_d   = S_FULL;
                    end else if (imem.ack) begin
                        deliver = 1'b1;
                    end
                end
                S_FULL: begin
                    if (!hold) begin
                        instr_d       = NOP_INSTR;
                        valid_d       = 1'b0;
                        skid_unload   = 1'b1;
                        state_d       = S_REQ;
                        deliver       = skid_valid;
                        deliver_instr = skid_instr;
                        deliver_pc    = skid_pc;
                    end
                end
                S_HALT: begin
                end
                default: state_d = S_REQ;
            endcase

            if (deliver) begin
                instr_d    = deliver_instr;
                pc_out_d   = deliver_pc;
                valid_d    = 1'b1;
                pc_d       = deliver_pc;
                req_addr_d = deliver_pc;
                if (deliver_instr[31:26] == HALT_OPCODE) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= 32'd0;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            squash_q   <= squash_on_reset;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            halt_q     <= halt_d;
            squash_q   <= squash_d;
            pending_q  <= pending_d;
        end
    end

    if_skid_buffer u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (imem.rdata),
        .pc_i     (next_pc),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    assign imem.req        = req;
    assign imem.addr       = req_addr_q;
    assign Instruction_out = instr_q;
    assign PC_out          = pc_out_q;
    assign inst_valid      = valid_q;
    assign halt_out        = halt_q;
    assign pc_current      = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a latency-programmable instruction memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] Instruction_out;
    logic [31:0] PC_out;
    logic        inst_valid;
    logic        halt_out;
    logic [31:0] pc_current;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .hold            (hold),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump_taken      (jump_taken),
        .jump_target     (jump_target),
        .imem            (imem),
        .Instruction_out (Instruction_out),
        .PC_out          (PC_out),
        .inst_valid      (inst_valid),
        .halt_out        (halt_out),
        .pc_current      (pc_current)
    );

    always #5 clk = ~clk;

    // Memory: once a request is seen it completes after lat cycles, even if req drops.
    int unsigned lat   = 0;
    int unsigned cnt_q = 0;
    logic        busy_q = 1'b0;
    logic [31:0] addr_q = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h2002_0007;
            32'h0000_0020: return 32'hB400_0000;
            default:       return 32'h2000_0000 | a;
        endcase
    endfunction

    assign imem.ack   = (busy_q || imem.req) && (cnt_q == lat);
    assign imem.rdata = mem_word(busy_q ? addr_q : imem.addr);

    always @(posedge clk) begin
        if (imem.ack) begin
            busy_q <= 1'b0;
            cnt_q  <= 0;
        end else if (busy_q || imem.req) begin
            if (!busy_q) addr_q <= imem.addr;
            busy_q <= 1'b1;
            cnt_q  <= cnt_q + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid);
        check({tag, "_instr"}, Instruction_out, instr);
        check({tag, "_pcout"}, PC_out, pc);
        check({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0;
        jump_taken = 1'b0; jump_target = 32'd0;
        step(); step();

        // Reset state
        expect_out("rst", NOP, 32'd0, 1'b0);
        check("rst_halt", {31'd0, halt_out}, 32'd0);
        check("rst_pc", pc_current, 32'd0);
        check("rst_req", {31'd0, imem.req}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'd0, imem.req}, 32'd1);
        check("post_rst_addr", imem.addr, 32'd0);

        // Same-cycle ack: one instruction per cycle
        step(); expect_out("f0", 32'h2001_0005, 32'h4, 1'b1);
        step(); expect_out("f1", 32'h2002_0007, 32'h8, 1'b1);

        // Three-cycle latency on 0x08
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lat_addr", imem.addr, 32'h8);
            check("lat_req", {31'd0, imem.req}, 32'd1);
            expect_out("lat_bubble", NOP, 32'h8, 1'b0);
        end
        step(); expect_out("lat_acc", 32'h2000_0008, 32'hC, 1'b1);

        // Branch while 0x0C is unacked: stale data dropped, then target fetched
        branch_taken = 1'b1; branch_target = 32'h40;
        step(); branch_taken = 1'b0;
        check("br_addr_hold", imem.addr, 32'hC);
        check("br_pc", pc_current, 32'h40);
        check("br_instr", Instruction_out, NOP);
        check("br_valid", {31'd0, inst_valid}, 32'd0);
        step(); step();
        step();
        check("br_addr_tgt", imem.addr, 32'h40);
        check("br_drop_instr", Instruction_out, NOP);
        check("br_drop_valid", {31'd0, inst_valid}, 32'd0);
        lat = 0;
        step(); expect_out("br_tgt", 32'h2000_0040, 32'h44, 1'b1);

        // Jump in the same cycle as an ack: data dropped, target requested next
        jump_taken = 1'b1; jump_target = 32'hC;
        step(); jump_taken = 1'b0;
        check("jmp_instr", Instruction_out, NOP);
        check("jmp_valid", {31'd0, inst_valid}, 32'd0);
        check("jmp_addr", imem.addr, 32'hC);
        check("jmp_pc", pc_current, 32'hC);
        step(); expect_out("jmp_tgt", 32'h2000_000C, 32'h10, 1'b1);

        // Hold for two cycles while the 0x10 ack arrives
        hold = 1'b1; lat = 1;
        step();
        expect_out("hold1", 32'h2000_000C, 32'h10, 1'b1);
        check("hold1_addr", imem.addr, 32'h10);
        check("hold1_pc", pc_current, 32'h10);
        step();
        expect_out("hold2", 32'h2000_000C, 32'h10, 1'b1);
        check("hold2_req", {31'd0, imem.req}, 32'd0);
        hold = 1'b0; lat = 0;
        step();
        expect_out("skid_rel", 32'h2000_0010, 32'h14, 1'b1);
        check("skid_rel_addr", imem.addr, 32'h14);

        // Run up to the halt word at 0x20
        step(); expect_out("seq14", 32'h2000_0014, 32'h18, 1'b1);
        step(); step();
        step(); expect_out("halt", 32'hB400_0000, 32'h24, 1'b1);
        check("halt_flag", {31'd0, halt_out}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_req", {31'd0, imem.req}, 32'd0);
        end
        expect_out("halt_frozen", 32'hB400_0000, 32'h24, 1'b1);
        check("halt_still", {31'd0, halt_out}, 32'd1);
        jump_taken = 1'b1; jump_target = 32'h80;
        step(); jump_taken = 1'b0;
        check("unhalt_flag", {31'd0, halt_out}, 32'd0);
        check("unhalt_valid", {31'd0, inst_valid}, 32'd0);
        check("unhalt_req", {31'd0, imem.req}, 32'd1);
        check("unhalt_addr", imem.addr, 32'h80);
        step(); expect_out("unhalt_tgt", 32'h2000_0080, 32'h84, 1'b1);

        // Reset while 0x84 is in flight; its late ack must be ignored
        lat = 2;
        step();
        reset = 1'b1;
        step(); reset = 1'b0;
        expect_out("rst2", NOP, 32'd0, 1'b0);
        check("rst2_pc", pc_current, 32'd0);
        #1;
        check("rst2_req", {31'd0, imem.req}, 32'd1);
        check("rst2_addr", imem.addr, 32'd0);
        step();
        expect_out("rst2_drop", NOP, 32'd0, 1'b0);
        check("rst2_readdr", imem.addr, 32'd0);
        lat = 0;
        step(); expect_out("rst2_first", 32'h2001_0005, 32'h4, 1'b1);

        // Branch outranks jump; PC wraps past the top of memory
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        jump_taken = 1'b1; jump_target = 32'h200;
        step(); branch_taken = 1'b0; jump_taken = 1'b0;
        check("prio_pc", pc_current, 32'hFFFF_FFFC);
        check("prio_addr", imem.addr, 32'hFFFF_FFFC);
        step();
        expect_out("wrap", 32'hFFFF_FFFC, 32'd0, 1'b1);
        check("wrap_pc", pc_current, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
